// File: rtl/branch_predictor_if.sv
// Fetch/resolve bundle between the pipeline and the branch predictor.
// Slave is the predictor; master is the fetch/resolve driver.
interface branch_predictor_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          fetch_valid;
    logic          fetch_is_branch;
    logic [15:0]   fetch_pc;
    logic          pred_taken;
    logic          q_full;
    logic [CW-1:0] q_count;
    logic          resolve_valid;
    logic          resolve_miss;
    logic          flush;
    logic [15:0]   miss_count;

    modport master (
        output fetch_valid, fetch_is_branch, fetch_pc,
        output resolve_valid, resolve_miss, flush,
        input  pred_taken, q_full, q_count, miss_count
    );

    modport slave (
        input  fetch_valid, fetch_is_branch, fetch_pc,
        input  resolve_valid, resolve_miss, flush,
        output pred_taken, q_full, q_count, miss_count
    );
endinterface

// File: rtl/branch_predictor.sv
// 2-bit saturating-counter branch predictor with an in-order in-flight branch queue.
// Latency: prediction is combinational; a resolve updates its counter for the next cycle.
// Backpressure: q_full refuses new branches (dropped); flush empties the queue after the current resolve.
module branch_predictor #(
    parameter int IDX_BITS = 4,
    parameter int DEPTH    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    branch_predictor_if.slave  bp
);
    localparam int PW      = $clog2(DEPTH);
    localparam int CW      = PW + 1;
    localparam int ENTRIES = 1 << IDX_BITS;

    logic [1:0]          ctr    [ENTRIES];
    logic [IDX_BITS-1:0] q_idx  [DEPTH];
    logic                q_pred [DEPTH];

    logic [PW-1:0]       head;
    logic [PW-1:0]       tail;
    logic [CW-1:0]       count;
    logic [15:0]         misses;

    logic [IDX_BITS-1:0] fetch_idx;
    logic [IDX_BITS-1:0] head_idx;
    logic                pred;
    logic                full;
    logic                push;
    logic                pop;
    logic                actual;

    assign fetch_idx = bp.fetch_pc[IDX_BITS-1:0];
    assign pred      = ctr[fetch_idx][1];
    assign full      = (count == CW'(DEPTH));
    assign push      = bp.fetch_valid && bp.fetch_is_branch && !full && !bp.flush;
    assign pop       = bp.resolve_valid && (count != '0);
    assign head_idx  = q_idx[head];
    // The outcome is recovered from the prediction stored at fetch time.
    assign actual    = q_pred[head] ^ bp.resolve_miss;

    assign bp.pred_taken = pred;
    assign bp.q_full     = full;
    assign bp.q_count    = count;
    assign bp.miss_count = misses;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr[i] <= 2'b01;
            end
        end else if (pop) begin
            if (actual) begin
                if (ctr[head_idx] != 2'b11) ctr[head_idx] <= ctr[head_idx] + 2'b01;
            end else begin
                if (ctr[head_idx] != 2'b00) ctr[head_idx] <= ctr[head_idx] - 2'b01;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_idx[tail]  <= fetch_idx;
            q_pred[tail] <= pred;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (bp.flush) begin
            // Push is already blocked by flush, so tail is stable; collapse onto it.
            head  <= tail;
            count <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misses <= '0;
        end else if (pop && bp.resolve_miss && (misses != 16'hFFFF)) begin
            misses <= misses + 16'd1;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench: stimulus drives and queues model predictions; a monitor compares on each falling edge.
module tb_branch_predictor;
    localparam int DEPTH   = 4;
    localparam int ENTRIES = 16;

    logic clk;
    logic rst_n;

    branch_predictor_if #(.DEPTH(DEPTH)) bpif();

    branch_predictor #(.IDX_BITS(4), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bp    (bpif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int    idx;
        bit    pred;
    } branch_t;

    typedef struct {
        bit    pred;
        int    cnt;
        bit    full;
        int    miss;
        string nm;
    } exp_t;

    int      m_ctr [ENTRIES];
    branch_t mq [$];
    int      m_miss;
    exp_t    sb [$];

    int n_chk  = 0;
    int n_fail = 0;

    function automatic void chk(string nm, int act, int expv);
        n_chk++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < ENTRIES; i++) m_ctr[i] = 1;
        mq.delete();
        m_miss = 0;
    endfunction

    task automatic drive(input bit fv, input bit fb, input logic [15:0] pc,
                         input bit rv, input bit rm, input bit fl);
        bpif.fetch_valid     = fv;
        bpif.fetch_is_branch = fb;
        bpif.fetch_pc        = pc;
        bpif.resolve_valid   = rv;
        bpif.resolve_miss    = rm;
        bpif.flush           = fl;
    endtask

    // One cycle of stimulus: queue what the outputs must show now, then advance the model past the edge.
    task automatic step(input bit fv, input bit fb, input logic [15:0] pc,
                        input bit rv, input bit rm, input bit fl, input string nm);
        exp_t    e;
        branch_t b;
        int      idx;
        @(posedge clk);
        #1;
        drive(fv, fb, pc, rv, rm, fl);
        idx    = int'(pc) % ENTRIES;
        e.pred = (m_ctr[idx] >= 2);
        e.cnt  = mq.size();
        e.full = (mq.size() == DEPTH);
        e.miss = m_miss;
        e.nm   = nm;
        sb.push_back(e);
        if (rv && mq.size() > 0) begin
            b = mq.pop_front();
            if (b.pred ^ rm) m_ctr[b.idx] = (m_ctr[b.idx] < 3) ? m_ctr[b.idx] + 1 : 3;
            else             m_ctr[b.idx] = (m_ctr[b.idx] > 0) ? m_ctr[b.idx] - 1 : 0;
            if (rm && m_miss < 65535) m_miss++;
        end
        if (fv && fb && !e.full && !fl) begin
            b.idx  = idx;
            b.pred = e.pred;
            mq.push_back(b);
        end
        if (fl) mq.delete();
    endtask

    // Drive a known branch outcome for idx: push it, then resolve it with the matching miss bit.
    task automatic outcome(input int idx, input bit taken, input string nm);
        step(1, 1, 16'(idx), 0, 0, 0, {nm, "_push"});
        step(0, 0, 16'(idx), 1, taken ^ (m_ctr[idx] >= 2), 0, {nm, "_pop"});
    endtask

    task automatic check_table(input string nm);
        for (int i = 0; i < ENTRIES; i++) begin
            chk($sformatf("%s_ctr%0d", nm, i), int'(dut.ctr[i]), m_ctr[i]);
        end
    endtask

    task automatic check_pred_all_zero(input string nm);
        for (int i = 0; i < ENTRIES; i++) begin
            bpif.fetch_pc = 16'(i);
            #1;
            chk($sformatf("%s_pred%0d", nm, i), int'(bpif.pred_taken), 0);
        end
    endtask

    // Reset lands between edges; resolve_valid stays high while rst_n is low and must be ignored.
    task automatic async_reset(input string nm);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        drive(0, 0, 16'h0, 1, 1, 0);
        #1;
        model_reset();
        chk({nm, "_qcount"}, int'(bpif.q_count), 0);
        chk({nm, "_miss"}, int'(bpif.miss_count), 0);
        check_table(nm);
        repeat (2) @(posedge clk);
        #3;
        drive(0, 0, 16'h0, 0, 0, 0);
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.nm, "_pred"},   int'(bpif.pred_taken), int'(e.pred));
            chk({e.nm, "_qcount"}, int'(bpif.q_count),    e.cnt);
            chk({e.nm, "_qfull"},  int'(bpif.q_full),     int'(e.full));
            chk({e.nm, "_miss"},   int'(bpif.miss_count), e.miss);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 16'h0, 0, 0, 0);
        model_reset();
        #7;
        chk("reset_qcount", int'(bpif.q_count), 0);
        chk("reset_qfull", int'(bpif.q_full), 0);
        chk("reset_miss", int'(bpif.miss_count), 0);
        check_table("reset");
        check_pred_all_zero("reset");
        #16;
        rst_n = 1'b1;

        // Mispredicted not-taken at pc 5 trains index 5 to weakly taken.
        step(1, 1, 16'h0005, 0, 0, 0, "r028_push");
        step(0, 0, 16'h0005, 1, 1, 0, "r028_pop");
        step(1, 0, 16'h0015, 0, 0, 0, "r028_alias");
        step(0, 0, 16'h0015, 0, 0, 0, "r028_hold");

        for (int k = 0; k < 4; k++) outcome(3, 1, $sformatf("r029_t%0d", k));
        outcome(3, 0, "r029_nt");
        step(0, 0, 16'h0003, 0, 0, 0, "r029_pred");

        for (int k = 0; k < 4; k++) step(1, 1, 16'(k + 8), 0, 0, 0, $sformatf("r030_push%0d", k));
        step(1, 1, 16'h000C, 1, 0, 0, "r030_drop");
        step(0, 0, 16'h000C, 0, 0, 0, "r030_after");
        step(0, 0, 16'h0000, 0, 0, 1, "r030_clear");

        for (int k = 0; k < 3; k++) step(1, 1, 16'(k + 6), 0, 0, 0, $sformatf("r031_push%0d", k));
        step(1, 1, 16'h0009, 1, 1, 1, "r031_flush");
        step(0, 0, 16'h0006, 1, 1, 0, "r031_late");
        step(0, 0, 16'h0006, 0, 0, 0, "r031_after");

        step(0, 0, 16'h0002, 1, 1, 0, "r032_empty");
        step(0, 0, 16'h0002, 0, 0, 0, "r032_after");
        check_table("r032");

        step(1, 1, 16'h0001, 0, 0, 0, "r033_push0");
        step(1, 1, 16'h0002, 0, 0, 0, "r033_push1");
        step(0, 0, 16'h0000, 0, 0, 0, "r033_idle");
        async_reset("r033");
        check_pred_all_zero("r033");

        for (int i = 0; i < 1500; i++) begin
            if (i == 700) async_reset("rand_rst");
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, 16'($urandom),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 19) == 0, "rand");
        end

        @(posedge clk);
        #1;
        drive(0, 0, 16'h0, 0, 0, 0);
        check_table("final");
        @(negedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
